// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encodings, digit limits and a digit validity helper.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // A digit at or above this value after a right shift gets 3 subtracted
  localparam logic [3:0] ADJ_THRESH = 4'd8;

  // True when a packed nibble is not a legal decimal digit
  function automatic logic digit_bad(input logic [3:0] d);
    return (d > BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Single-digit correction cell for reverse double-dabble: after the right
// shift a digit of 8 or more has picked up half of a "10" from its upper
// neighbour, so subtracting 3 restores a proper decimal digit.
module bcd_sub3
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter. A start in IDLE loads the packed BCD
// value; each SHIFT cycle moves one bit from the BCD register into the binary
// register and corrects every digit. Invalid digits skip straight to DONE with
// err set and a zero result.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4*DIGITS;

  state_t               state;
  state_t               state_nxt;
  logic [BCD_W-1:0]     bcd_r;
  logic [BIN_W-1:0]     bin_r;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_W-1:0]     bin_out_r;
  logic                 err_r;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_adj;
  logic                   any_bad;
  logic                   accept;
  logic                   last_step;

  // Combined datapath shifted right by one with a zero entering the BCD MSB
  assign shifted = {bcd_r, bin_r} >> 1;

  // One correction cell per digit of the freshly shifted BCD part
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_sub3 u_sub3 (
      .din  (shifted[BIN_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Flag any illegal digit in the incoming value
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(bcd_in[4*i +: 4])) any_bad = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = any_bad ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last_step = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift registers, iteration counter and held result registers; the result
  // is captured on the final step so it is already valid while done is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_r     <= '0;
      bin_r     <= '0;
      cnt       <= '0;
      bin_out_r <= '0;
      err_r     <= 1'b0;
    end else if (accept) begin
      bcd_r <= bcd_in;
      bin_r <= '0;
      cnt   <= CNT_W'(BIN_W);
      err_r <= any_bad;
      if (any_bad) bin_out_r <= '0;
    end else if (state == ST_SHIFT) begin
      bcd_r <= bcd_adj;
      bin_r <= shifted[BIN_W-1:0];
      cnt   <= cnt - CNT_W'(1);
      if (last_step) bin_out_r <= shifted[BIN_W-1:0];
    end
  end

  assign bin_out = bin_out_r;
  assign err     = err_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for the BCD-to-binary converter: latency, busy window,
// invalid digits, ignored starts, mid-run reset, back-to-back runs and a
// strided sweep against the decimal value of each input.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int checks;
  int errors;

  bcd_to_bin_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Run one conversion and check latency, busy window and result
  task automatic applyStimulus(input logic [15:0] bcd, input logic [13:0] exp_bin,
                               input logic exp_err, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, exp_err ? 1 : 15);
    checkOutput({tag, "_busycycles"}, busy_cnt, exp_err ? 0 : 14);
    checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    checkOutput({tag, "_bin"}, {18'd0, bin_out}, {18'd0, exp_bin});
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, {31'd0, done}, 0);
  endtask

  // Pack a decimal value into 4 BCD digits
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  initial begin
    int done_cnt;
    int t1;
    int t2;
    logic [13:0] r1;
    logic [13:0] r2;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);
    checkOutput("reset_err", {31'd0, err}, 0);
    checkOutput("reset_bin", {18'd0, bin_out}, 0);
    rst = 1'b0;

    // Basic conversions and invalid digit
    applyStimulus(16'h0000, 14'd0, 1'b0, "t1_zero");
    applyStimulus(16'h1234, 14'h04D2, 1'b0, "t2_1234");
    applyStimulus(16'h9999, 14'h270F, 1'b0, "t2_9999");
    applyStimulus(16'h12A4, 14'd0, 1'b1, "t3_bad_digit");
    applyStimulus(16'h0010, 14'd10, 1'b0, "t2_ten");
    applyStimulus(16'hF000, 14'd0, 1'b1, "t3_bad_top");

    // Start during SHIFT is ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0567;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    r1       = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        start  = 1'b1;
        bcd_in = 16'h0999;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        r1 = bin_out;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("t4_done_pulses", done_cnt, 1);
    checkOutput("t4_result", {18'd0, r1}, 567);

    // Reset at cycle 7 aborts the conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", {31'd0, busy}, 0);
    checkOutput("t5_rst_done", {31'd0, done}, 0);
    checkOutput("t5_rst_err", {31'd0, err}, 0);
    checkOutput("t5_rst_bin", {18'd0, bin_out}, 0);
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("t5_no_done", done_cnt, 0);
    applyStimulus(16'h0042, 14'd42, 1'b0, "t5_after");

    // Back-to-back with start held high
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0001;
    @(negedge clk);
    bcd_in   = 16'h0100;
    done_cnt = 0;
    t1 = 0;
    t2 = 0;
    r1 = '0;
    r2 = '0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          t1 = c;
          r1 = bin_out;
        end else if (done_cnt == 2) begin
          t2 = c;
          r2 = bin_out;
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("t6_done_pulses", done_cnt, 2);
    checkOutput("t6_first_at", t1, 15);
    checkOutput("t6_spacing", t2 - t1, 16);
    checkOutput("t6_result1", {18'd0, r1}, 1);
    checkOutput("t6_result2", {18'd0, r2}, 100);

    // Strided sweep against the decimal value, plus the top end
    for (int v = 0; v < 10000; v += 97) begin
      applyStimulus(to_bcd(v), 14'(v), 1'b0, "sweep");
    end
    applyStimulus(to_bcd(9998), 14'd9998, 1'b0, "sweep_9998");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
